sram_byte_write_packer: RTL and testbench
=========================================

// Module: sram_byte_write_packer
// PURPOSE
//   Upstream write stage for the 32-bit-write / 8-bit-read scratchpad SRAM.
//   Accepts a valid/ready byte stream and packs 4 bytes per word,
//   byte k into din[8k+7:8k], so byte address {word_addr,k} reads back byte k.
//   Drives the SRAM write port (csb0/addr0/din0) from an auto-incrementing word
//   address, one byte/cycle sustained, and reports completion to the controller.
// PARAMETERS
//   BYTE_WIDTH        8     width of one input beat
//   WRITE_WIDTH       32    SRAM write word width (4 bytes)
//   WRITE_ADDR_WIDTH  11    SRAM word address width (2048 words)
// PORTS
//   clk             in   1    single clock; also drives SRAM clk0
//   reset           in   1    synchronous, active-high
//   cfg_start       in   1    pulse: begin a transfer (ignored while busy)
//   cfg_base_addr   in   11   first word address
//   cfg_num_words   in   12   words to write, 0..2048
//   s_valid         in   1    input byte valid
//   s_data          in   8    input byte
//   s_last          in   1    final byte of stream (qualified by s_valid)
//   s_ready         out  1    byte accepted when s_valid & s_ready
//   sram_csb0       out  1    active-low write select to SRAM port 0
//   sram_addr0      out  11   SRAM word address
//   sram_din0       out  32   SRAM write data
//   busy            out  1    transfer in progress
//   done            out  1    one-cycle completion pulse
//   short_xfer      out  1    valid with done: s_last ended stream before count
// BEHAVIOUR
//   Reset: s_ready=0, sram_csb0=1, sram_addr0=0, sram_din0=0, busy=0, done=0,
//     short_xfer=0; state IDLE; byte lane idx=0, word counter=0.
//   All outputs registered. States: IDLE, FILL, DONE.
//   IDLE: s_ready=0. cfg_start & num_words!=0 -> latch base/count, FILL next
//     cycle (busy=1, s_ready=1). cfg_start & num_words==0 -> done=1 next cycle,
//     short_xfer=0, no write, stay IDLE.
//   FILL: s_ready=1. Accepted byte goes to lane idx, idx increments.
//     Word completes on acceptance of lane 3 OR s_last. In the next cycle:
//     sram_csb0=0 for exactly one cycle, sram_addr0=current word address,
//     sram_din0=packed word; lanes not written in a partial word are 0.
//     Acceptance continues in that same cycle (no bubble, lane idx back to 0).
//   Address: increments after each strobe, wraps 2047 -> 0.
//   Termination (decided on completing word): words_written == num_words, or
//     s_last. s_ready drops in the strobe cycle of the final word; DONE state
//     next cycle: done=1, short_xfer=(words_written < num_words), busy=1;
//     then IDLE, busy=0. Final strobe precedes done by exactly 1 cycle, so the
//     SRAM write is complete before the consumer reads.
//   s_last on final counted byte: normal completion, short_xfer=0.
//   Count reached without s_last: completion; further bytes are not accepted.
//   sram_csb0 high whenever no strobe; addr0/din0 hold last value.
//   cfg_start while busy: ignored, latched config unchanged.
//   reset mid-transfer: next edge returns to reset values; partially
//     packed bytes discarded, no write strobe issued.
// TESTING
//   1 base=0,num=2, bytes 01..08 continuous -> strobes addr0=0 din0=04030201,
//     addr0=1 din0=08070605 on back-to-back words; done 1 cycle after last, short=0.
//   2 base=5,num=4, s_last on 6th byte AA..AF -> writes 5:ADACABAA, 6:0000AFAE;
//     done with short_xfer=1; s_ready=0 after.
//   3 base=2047,num=2 -> strobes at addr 2047 then 0 (wrap).
//   4 s_valid toggling 1/0 every cycle -> same words as test 1, csb0 low
//     exactly once per 4 accepted bytes.
//   5 reset asserted after 2 bytes of word -> csb0 stays 1, busy=0, done=0;
//     fresh start afterwards writes correct packing from lane 0.
//   6 num=0 -> done next cycle, no strobe; cfg_start while busy ignored.

Source files
------------

// File: rtl/sram_byte_write_packer_if.sv
// Byte-stream valid/ready bundle feeding the SRAM write packer.
interface sram_byte_write_packer_if #(
    parameter int BYTE_WIDTH = 8
);
    logic                  s_valid;
    logic [BYTE_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  s_ready;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready
    );
endinterface

// File: rtl/sram_byte_write_packer.sv
// Packs a byte stream into 32-bit words and writes them to SRAM port 0
// at an auto-incrementing word address, one byte per cycle sustained.
module sram_byte_write_packer #(
    parameter int BYTE_WIDTH       = 8,
    parameter int WRITE_WIDTH      = 32,
    parameter int WRITE_ADDR_WIDTH = 11
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_start,
    input  logic [WRITE_ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [WRITE_ADDR_WIDTH:0]   cfg_num_words,
    sram_byte_write_packer_if.slave     s,
    output logic                        sram_csb0,
    output logic [WRITE_ADDR_WIDTH-1:0] sram_addr0,
    output logic [WRITE_WIDTH-1:0]      sram_din0,
    output logic                        busy,
    output logic                        done,
    output logic                        short_xfer
);
    localparam int LANES = WRITE_WIDTH / BYTE_WIDTH;
    localparam int IW    = $clog2(LANES);
    localparam int CW    = WRITE_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                      state_q, state_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [WRITE_WIDTH-1:0]      pack_q, pack_d, word;
    logic [WRITE_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [CW-1:0]               num_q, num_d;
    logic                        ready_d, csb_d;
    logic                        busy_d, done_d, short_d;
    logic [WRITE_ADDR_WIDTH-1:0] addr_d;
    logic [WRITE_WIDTH-1:0]      din_d;
    logic                        accept, word_end, last_word;

    assign accept    = (state_q == FILL) && s.s_valid && s.s_ready;
    assign word      = pack_q
                     | (WRITE_WIDTH'(s.s_data) << (idx_q * BYTE_WIDTH));
    assign word_end  = accept && (idx_q == IW'(LANES - 1) || s.s_last);
    assign last_word = word_end
                     && ((cnt_q + 1'b1) == num_q || s.s_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pack_q     <= '0;
            waddr_q    <= '0;
            cnt_q      <= '0;
            num_q      <= '0;
            s.s_ready  <= 1'b0;
            sram_csb0  <= 1'b1;
            sram_addr0 <= '0;
            sram_din0  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            short_xfer <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pack_q     <= pack_d;
            waddr_q    <= waddr_d;
            cnt_q      <= cnt_d;
            num_q      <= num_d;
            s.s_ready  <= ready_d;
            sram_csb0  <= csb_d;
            sram_addr0 <= addr_d;
            sram_din0  <= din_d;
            busy       <= busy_d;
            done       <= done_d;
            short_xfer <= short_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_start && !busy && cfg_num_words != '0)
                    state_d = FILL;
            end
            FILL: begin
                if (last_word)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // busy is still high in the done cycle, so a start there is ignored
    always_comb begin
        idx_d   = idx_q;
        pack_d  = pack_q;
        waddr_d = waddr_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        ready_d = 1'b0;
        csb_d   = 1'b1;
        addr_d  = sram_addr0;
        din_d   = sram_din0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        short_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_start && !busy) begin
                    if (cfg_num_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        waddr_d = cfg_base_addr;
                        num_d   = cfg_num_words;
                        cnt_d   = '0;
                        idx_d   = '0;
                        pack_d  = '0;
                        ready_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            FILL: begin
                busy_d  = 1'b1;
                ready_d = !last_word;
                if (accept) begin
                    idx_d  = idx_q + 1'b1;
                    pack_d = word;
                end
                if (word_end) begin
                    idx_d   = '0;
                    pack_d  = '0;
                    csb_d   = 1'b0;
                    addr_d  = waddr_q;
                    din_d   = word;
                    waddr_d = waddr_q + 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                short_d = cnt_q < num_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sram_byte_write_packer.sv
// Self-checking bench for sram_byte_write_packer: directed cases plus
// randomized transfers checked against a byte-list packing model.
module tb_sram_byte_write_packer;
    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start;
    logic [10:0] cfg_base_addr;
    logic [11:0] cfg_num_words;
    logic        sram_csb0;
    logic [10:0] sram_addr0;
    logic [31:0] sram_din0;
    logic        busy, done, short_xfer;

    sram_byte_write_packer_if bus();

    sram_byte_write_packer dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_start    (cfg_start),
        .cfg_base_addr(cfg_base_addr),
        .cfg_num_words(cfg_num_words),
        .s            (bus),
        .sram_csb0    (sram_csb0),
        .sram_addr0   (sram_addr0),
        .sram_din0    (sram_din0),
        .busy         (busy),
        .done         (done),
        .short_xfer   (short_xfer)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] a;
        logic [31:0] d;
        int          c;
    } wr_t;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    wr_t        got[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic       done_short = 1'b0;
    logic [7:0] stream[$];
    int         accepted;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t w;
        if (sram_csb0 === 1'b0) begin
            w.a = sram_addr0;
            w.d = sram_din0;
            w.c = cyc;
            got.push_back(w);
        end
        if (done === 1'b1) begin
            done_cnt   = done_cnt + 1;
            done_cyc   = cyc;
            done_short = short_xfer;
        end
    end

    // mode: 0 continuous valid, 1 toggling valid, 2 random valid
    task automatic run_xfer(input logic [10:0] base,
                            input logic [11:0] num,
                            input int last_at,
                            input int mode,
                            input bit poke);
        int  i;
        bit  tog;
        logic v;
        @(negedge clk);
        cfg_base_addr = base;
        cfg_num_words = num;
        cfg_start     = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        i   = 0;
        tog = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            if (bus.s_ready !== 1'b1) break;
            if (poke) begin
                cfg_start     = (k == 1);
                cfg_base_addr = 11'd200;
                cfg_num_words = 12'd5;
            end
            if (mode == 0) v = 1'b1;
            else if (mode == 1) v = tog;
            else v = 1'($urandom_range(0, 1));
            if (i >= stream.size()) v = 1'b0;
            bus.s_valid = v;
            bus.s_data  = v ? stream[i] : 8'($urandom);
            bus.s_last  = v && (i == last_at);
            if (v) i++;
            tog = !tog;
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        cfg_start   = 1'b0;
        accepted    = i;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.s_ready, sram_csb0, busy, done, short_xfer} !== 5'b01000) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=01000",
                     {bus.s_ready, sram_csb0, busy, done, short_xfer});
        end
        total++;
        if (sram_addr0 !== 11'd0 || sram_din0 !== 32'd0) begin
            bad++;
            $display("FAIL reset_bus addr=%h din=%h exp=0", sram_addr0, sram_din0);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic(input int mode, input int gap);
        int gs = got.size();
        int dn = done_cnt;
        stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_xfer(11'd0, 12'd2, -1, mode, 1'b0);
        total++;
        if (got.size() - gs !== 2) begin
            bad++;
            $display("FAIL basic%0d_count got=%0d exp=2", mode, got.size() - gs);
        end else begin
            total++;
            if (got[gs].a !== 11'd0 || got[gs].d !== 32'h04030201) begin
                bad++;
                $display("FAIL basic%0d_w0 got=%h:%h exp=0:04030201",
                         mode, got[gs].a, got[gs].d);
            end
            total++;
            if (got[gs+1].a !== 11'd1 || got[gs+1].d !== 32'h08070605) begin
                bad++;
                $display("FAIL basic%0d_w1 got=%h:%h exp=1:08070605",
                         mode, got[gs+1].a, got[gs+1].d);
            end
            total++;
            if (got[gs+1].c - got[gs].c !== gap) begin
                bad++;
                $display("FAIL basic%0d_gap got=%0d exp=%0d",
                         mode, got[gs+1].c - got[gs].c, gap);
            end
            total++;
            if (done_cnt !== dn + 1 || done_cyc !== got[gs+1].c + 1) begin
                bad++;
                $display("FAIL basic%0d_done n=%0d cyc=%0d exp_cyc=%0d",
                         mode, done_cnt - dn, done_cyc, got[gs+1].c + 1);
            end
        end
        total++;
        if (done_short !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic%0d_end short=%b busy=%b exp=0,0",
                     mode, done_short, busy);
        end
    endtask

    task automatic test_short();
        int gs = got.size();
        stream = '{8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF};
        run_xfer(11'd5, 12'd4, 5, 0, 1'b0);
        total++;
        if (got.size() - gs !== 2) begin
            bad++;
            $display("FAIL short_count got=%0d exp=2", got.size() - gs);
        end else begin
            total++;
            if (got[gs].a !== 11'd5 || got[gs].d !== 32'hADACABAA) begin
                bad++;
                $display("FAIL short_w0 got=%h:%h exp=5:ADACABAA",
                         got[gs].a, got[gs].d);
            end
            total++;
            if (got[gs+1].a !== 11'd6 || got[gs+1].d !== 32'h0000AFAE) begin
                bad++;
                $display("FAIL short_w1 got=%h:%h exp=6:0000AFAE",
                         got[gs+1].a, got[gs+1].d);
            end
        end
        total++;
        if (done_short !== 1'b1 || bus.s_ready !== 1'b0) begin
            bad++;
            $display("FAIL short_flag short=%b ready=%b exp=1,0",
                     done_short, bus.s_ready);
        end
    endtask

    task automatic test_wrap();
        int gs = got.size();
        stream = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        run_xfer(11'd2047, 12'd2, -1, 0, 1'b0);
        total++;
        if (got.size() - gs !== 2) begin
            bad++;
            $display("FAIL wrap_count got=%0d exp=2", got.size() - gs);
        end else begin
            total++;
            if (got[gs].a !== 11'd2047 || got[gs+1].a !== 11'd0) begin
                bad++;
                $display("FAIL wrap_addr got=%0d,%0d exp=2047,0",
                         got[gs].a, got[gs+1].a);
            end
            total++;
            if (got[gs+1].d !== 32'h80706050) begin
                bad++;
                $display("FAIL wrap_data got=%h exp=80706050", got[gs+1].d);
            end
        end
    endtask

    task automatic test_reset_mid();
        int gs = got.size();
        int dn = done_cnt;
        @(negedge clk);
        cfg_base_addr = 11'd9;
        cfg_num_words = 12'd3;
        cfg_start     = 1'b1;
        @(negedge clk);
        cfg_start   = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h11;
        @(negedge clk);
        bus.s_data  = 8'h22;
        @(negedge clk);
        bus.s_valid = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({sram_csb0, busy, done, bus.s_ready} !== 4'b1000) begin
            bad++;
            $display("FAIL rstmid_out got=%b exp=1000",
                     {sram_csb0, busy, done, bus.s_ready});
        end
        repeat (3) @(negedge clk);
        total++;
        if (got.size() !== gs || done_cnt !== dn) begin
            bad++;
            $display("FAIL rstmid_quiet writes=%0d dones=%0d exp=0,0",
                     got.size() - gs, done_cnt - dn);
        end
        stream = '{8'h55, 8'h66, 8'h77, 8'h88};
        run_xfer(11'd9, 12'd1, -1, 0, 1'b0);
        total++;
        if (got.size() - gs !== 1) begin
            bad++;
            $display("FAIL rstmid_count got=%0d exp=1", got.size() - gs);
        end else if (got[gs].a !== 11'd9 || got[gs].d !== 32'h88776655) begin
            bad++;
            $display("FAIL rstmid_word got=%h:%h exp=9:88776655",
                     got[gs].a, got[gs].d);
        end
    endtask

    task automatic test_zero_busy();
        int gs = got.size();
        int dn = done_cnt;
        stream = '{};
        run_xfer(11'd300, 12'd0, -1, 0, 1'b0);
        total++;
        if (done_cnt !== dn + 1 || got.size() !== gs || done_short !== 1'b0) begin
            bad++;
            $display("FAIL zero_num dones=%0d writes=%0d short=%b exp=1,0,0",
                     done_cnt - dn, got.size() - gs, done_short);
        end
        gs     = got.size();
        dn     = done_cnt;
        stream = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
        run_xfer(11'd100, 12'd1, -1, 0, 1'b1);
        total++;
        if (got.size() - gs !== 1) begin
            bad++;
            $display("FAIL busy_start_count got=%0d exp=1", got.size() - gs);
        end else if (got[gs].a !== 11'd100 || got[gs].d !== 32'hC4C3C2C1) begin
            bad++;
            $display("FAIL busy_start_word got=%h:%h exp=100:C4C3C2C1",
                     got[gs].a, got[gs].d);
        end
        total++;
        if (done_cnt !== dn + 1 || busy !== 1'b0 || accepted !== 4) begin
            bad++;
            $display("FAIL busy_start_end dones=%0d busy=%b acc=%0d exp=1,0,4",
                     done_cnt - dn, busy, accepted);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            int          gs = got.size();
            int          dn = done_cnt;
            logic [10:0] base = 11'($urandom);
            int          num = $urandom_range(1, 6);
            int          last_at = -1;
            int          acc, words;
            bit          shrt;
            stream = '{};
            for (int i = 0; i < 4 * num + 4; i++)
                stream.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1)
                last_at = $urandom_range(0, 4 * num + 3);
            acc = 4 * num;
            if (last_at >= 0 && last_at + 1 < acc) acc = last_at + 1;
            words = (acc + 3) / 4;
            shrt  = words < num;
            run_xfer(base, 12'(num), last_at, 2, 1'b0);
            total++;
            if (got.size() - gs !== words || accepted !== acc) begin
                bad++;
                $display("FAIL rand%0d_count words=%0d acc=%0d exp=%0d,%0d",
                         t, got.size() - gs, accepted, words, acc);
                continue;
            end
            for (int w = 0; w < words; w++) begin
                logic [31:0] ed = '0;
                logic [10:0] ea = base + 11'(w);
                for (int j = 0; j < 4; j++)
                    if (4 * w + j < acc) ed[8*j +: 8] = stream[4*w + j];
                total++;
                if (got[gs+w].a !== ea || got[gs+w].d !== ed) begin
                    bad++;
                    $display("FAIL rand%0d_w%0d got=%h:%h exp=%h:%h",
                             t, w, got[gs+w].a, got[gs+w].d, ea, ed);
                end
            end
            total++;
            if (done_cnt !== dn + 1 || done_short !== shrt
                || done_cyc !== got[gs+words-1].c + 1) begin
                bad++;
                $display("FAIL rand%0d_done n=%0d short=%b cyc=%0d exp=1,%b,%0d",
                         t, done_cnt - dn, done_short, done_cyc,
                         shrt, got[gs+words-1].c + 1);
            end
            total++;
            if (bus.s_ready !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rand%0d_idle ready=%b busy=%b exp=0,0",
                         t, bus.s_ready, busy);
            end
        end
    endtask

    initial begin
        cfg_start     = 1'b0;
        cfg_base_addr = '0;
        cfg_num_words = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        test_reset();
        test_basic(0, 4);
        test_basic(1, 8);
        test_short();
        test_wrap();
        test_reset_mid();
        test_zero_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
